// File: rtl/axis_bitrate_pkg.sv
// rtl/axis_bitrate_pkg.sv - shared state type and saturation helper for the axis_bitrate monitor
package axis_bitrate_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // All-ones value of the given width (widths up to 64).
    function automatic logic [63:0] sat_value(input int unsigned width);
        return {64{1'b1}} >> (64 - width);
    endfunction

endpackage

// File: rtl/axis_bitrate_sat_cnt.sv
// rtl/axis_bitrate_sat_cnt.sv - saturating counter with clear, load-one and increment controls
module axis_bitrate_sat_cnt
    import axis_bitrate_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load_one,
    input  logic             incr,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_inc
);

    localparam logic [WIDTH-1:0] SAT = WIDTH'(sat_value(WIDTH));

    // count_inc is the value a publish would report if this cycle also counts.
    assign count_inc = (count == SAT) ? SAT : count + WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load_one) begin
            count <= WIDTH'(1);
        end else if (incr) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/axis_bitrate.sv
// rtl/axis_bitrate.sv - passive AXI-Stream packet length monitor; AXIS_BITRATE_CYCLES_EN adds o_cycles
module axis_bitrate
    import axis_bitrate_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_valid,
    input  logic                  i_ready,
    input  logic                  i_last,
    output logic [DATA_WIDTH-1:0] o_bit_rate,
`ifdef AXIS_BITRATE_CYCLES_EN
    output logic [DATA_WIDTH-1:0] o_cycles,
`endif
    output logic                  o_bit_rate_valid
);

    state_t state_q;
    state_t state_d;

    logic beat;
    logic pkt_end;
    logic cnt_clear;
    logic first_beat;
    logic more_beat;

    logic [DATA_WIDTH-1:0] beat_cnt;
    logic [DATA_WIDTH-1:0] beat_inc;
    logic [DATA_WIDTH-1:0] beat_pub;

    assign beat       = i_en & i_valid & i_ready;
    assign pkt_end    = beat & i_last;
    assign cnt_clear  = ~i_en | pkt_end;
    assign first_beat = beat & ~i_last & (state_q == IDLE);
    assign more_beat  = beat & ~i_last & (state_q == COUNT);
    assign beat_pub   = (state_q == IDLE) ? DATA_WIDTH'(1) : beat_inc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (beat && !i_last) state_d = COUNT;
            COUNT:   if (pkt_end)         state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Disable discards any open packet.
        if (!i_en) begin
            state_d = IDLE;
        end
    end

    axis_bitrate_sat_cnt #(
        .WIDTH(DATA_WIDTH)
    ) u_beat_cnt (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .clear     (cnt_clear),
        .load_one  (first_beat),
        .incr      (more_beat),
        .count     (beat_cnt),
        .count_inc (beat_inc)
    );

`ifdef AXIS_BITRATE_CYCLES_EN
    logic                  cyc_incr;
    logic [DATA_WIDTH-1:0] cyc_cnt;
    logic [DATA_WIDTH-1:0] cyc_inc;
    logic [DATA_WIDTH-1:0] cyc_pub;

    // Every cycle of an open packet counts, whether or not it carries a beat.
    assign cyc_incr = i_en & (state_q == COUNT) & ~pkt_end;
    assign cyc_pub  = (state_q == IDLE) ? DATA_WIDTH'(1) : cyc_inc;

    axis_bitrate_sat_cnt #(
        .WIDTH(DATA_WIDTH)
    ) u_cyc_cnt (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .clear     (cnt_clear),
        .load_one  (first_beat),
        .incr      (cyc_incr),
        .count     (cyc_cnt),
        .count_inc (cyc_inc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bit_rate       <= '0;
            o_cycles         <= '0;
            o_bit_rate_valid <= 1'b0;
        end else begin
            o_bit_rate_valid <= pkt_end;
            if (pkt_end) begin
                o_bit_rate <= beat_pub;
                o_cycles   <= cyc_pub;
            end
        end
    end
`else
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bit_rate       <= '0;
            o_bit_rate_valid <= 1'b0;
        end else begin
            o_bit_rate_valid <= pkt_end;
            if (pkt_end) begin
                o_bit_rate <= beat_pub;
            end
        end
    end
`endif

    logic unused_cnt;
    assign unused_cnt = ^beat_cnt;

endmodule

// File: tb/tb_axis_bitrate.sv
// tb/tb_axis_bitrate.sv - directed self-checking bench for axis_bitrate (32-bit and 4-bit instances)
module tb_axis_bitrate;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en;
    logic        valid;
    logic        ready;
    logic        last;
    logic [31:0] br;
    logic        brv;
    logic [3:0]  br4;
    logic        brv4;
`ifdef AXIS_BITRATE_CYCLES_EN
    logic [31:0] cy;
    logic [3:0]  cy4;
`endif

    int errors = 0;
    int checks = 0;
    int strb   = 0;
    int strb4  = 0;
    int cyc    = 0;

    axis_bitrate #(.DATA_WIDTH(32)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_en             (en),
        .i_valid          (valid),
        .i_ready          (ready),
        .i_last           (last),
        .o_bit_rate       (br),
`ifdef AXIS_BITRATE_CYCLES_EN
        .o_cycles         (cy),
`endif
        .o_bit_rate_valid (brv)
    );

    axis_bitrate #(.DATA_WIDTH(4)) dut4 (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_en             (en),
        .i_valid          (valid),
        .i_ready          (ready),
        .i_last           (last),
        .o_bit_rate       (br4),
`ifdef AXIS_BITRATE_CYCLES_EN
        .o_cycles         (cy4),
`endif
        .o_bit_rate_valid (brv4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (brv === 1'b1)  strb++;
        if (brv4 === 1'b1) strb4++;
    endtask

    task automatic drive(input logic v, input logic r, input logic l);
        valid = v;
        ready = r;
        last  = l;
    endtask

    task automatic send_pkt(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b1, (i == n - 1));
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int beats;
        int guard;
        int first_c;
        int last_c;
        logic v;
        logic r;
        logic hs;
        logic l;

        rst_n = 1'b0;
        en    = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        #1;
        check("rst_br", br, 0);
        check("rst_valid", brv, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("idle_strobes", strb, 0);
        check("idle_br", br, 0);

        // 100 back-to-back beats
        en = 1'b1;
        s0 = strb;
        send_pkt(100);
        check("p100_valid", brv, 1);
        check("p100_br", br, 100);
        check("p100_sat4", br4, 15);
        tick();
        check("p100_drop", brv, 0);
        check("p100_hold", br, 100);
        check("p100_strobes", strb - s0, 1);

        // 250 beats with random gaps and stray last pulses
        s0      = strb;
        beats   = 0;
        guard   = 0;
        first_c = 0;
        last_c  = 0;
        while (beats < 250 && guard < 5000) begin
            v  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 3) != 0);
            hs = v & r;
            l  = hs ? (beats == 249) : 1'($urandom_range(0, 1));
            drive(v, r, l);
            tick();
            guard++;
            if (hs) begin
                if (beats == 0)   first_c = cyc;
                if (beats == 249) last_c  = cyc;
                beats++;
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        check("rnd_beats", beats, 250);
        check("rnd_valid", brv, 1);
        check("rnd_br", br, 250);
        check("rnd_strobes", strb - s0, 1);
`ifdef AXIS_BITRATE_CYCLES_EN
        check("rnd_cycles", cy, last_c - first_c + 1);
`endif
        tick();

        // Three single-beat packets
        s0 = strb;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1);
            tick();
            check("b2b_valid", brv, 1);
            check("b2b_br", br, 1);
        end
        drive(1'b0, 1'b0, 1'b0);
        tick();
        check("b2b_drop", brv, 0);
        check("b2b_strobes", strb - s0, 3);

        // Abort a packet with i_en low, then a fresh 50-beat packet
        s0 = strb;
        for (int i = 0; i < 120; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            tick();
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, (i == 1));
            tick();
            check("dis_valid", brv, 0);
        end
        en = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        tick();
        check("dis_no_strobe", strb - s0, 0);
        check("dis_hold", br, 1);
        send_pkt(50);
        check("re_valid", brv, 1);
        check("re_br", br, 50);
`ifdef AXIS_BITRATE_CYCLES_EN
        check("re_cycles", cy, 50);
`endif
        check("re_strobes", strb - s0, 1);
        tick();

        // Saturation on the 4-bit instance, then reset mid-packet
        s0 = strb4;
        send_pkt(20);
        check("sat_valid4", brv4, 1);
        check("sat_br4", br4, 15);
        check("sat_br32", br, 20);
`ifdef AXIS_BITRATE_CYCLES_EN
        check("sat_cycles4", cy4, 15);
`endif
        check("sat_strobes4", strb4 - s0, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            tick();
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_br", br, 0);
        check("mid_rst_br4", br4, 0);
        check("mid_rst_valid", brv, 0);
`ifdef AXIS_BITRATE_CYCLES_EN
        check("mid_rst_cycles", cy, 0);
`endif
        s0 = strb;
        drive(1'b1, 1'b1, 1'b1);
        repeat (2) tick();
        drive(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("mid_rst_no_strobe", strb - s0, 0);
        send_pkt(2);
        check("post_rst_br", br, 2);
        check("post_rst_valid", brv, 1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
